// File: rtl/recovery_pkg.sv
// recovery_pkg: shared state encoding and sizing helpers for the recovery scheduler
package recovery_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_HALT     = 3'd1;
    localparam logic [STATE_W-1:0] ST_COPY_SPC = 3'd2;
    localparam logic [STATE_W-1:0] ST_COPY_GPR = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESUME   = 3'd4;
    localparam logic [STATE_W-1:0] ST_FATAL    = 3'd5;

    localparam int NUM_SPC_DEF = 4;

    function automatic int core_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending bit at or after ptr
//   pend  : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot winner
//   valid : any request present
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Lowest pending index overall is the wrap-around fallback; any pending
    // index at or above ptr overrides it, lowest such index last.
    always_comb begin
        grant = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pend[i]) grant = N'(1) << i;
        for (int i = N - 1; i >= 0; i--)
            if (pend[i] && i >= int'(ptr)) grant = N'(1) << i;
    end

    assign valid = |pend;

endmodule

// File: rtl/recovery_scheduler.sv
// recovery_scheduler: rollback recovery arbiter driving a shared register-file copy port
//   clk_i/rst_ni      : clock, async active-low reset
//   error_i           : per-core error strobes
//   halt_o/resume_o   : per-core halt level and one-cycle resume pulse
//   rf_req_o/rf_gnt_i : copy-port handshake; rf_spc_o selects bank, rf_addr_o the index
//   src_o/tgt_o       : copy source and target core
//   busy_o/done_o/fatal_o : status
//   Optional RECOVERY_TIMEOUT_EN: give up to FATAL after TIMEOUT_CYCLES without a grant.
module recovery_scheduler
    import recovery_pkg::*;
#(
    parameter int NUM_CORES      = 3,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_SPC        = NUM_SPC_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_CORES-1:0]                 error_i,
    output logic [NUM_CORES-1:0]                 halt_o,
    output logic [NUM_CORES-1:0]                 resume_o,
    output logic                                 rf_req_o,
    input  logic                                 rf_gnt_i,
    output logic                                 rf_spc_o,
    output logic [ADDR_WIDTH-1:0]                rf_addr_o,
    output logic [core_idx_w(NUM_CORES)-1:0]     src_o,
    output logic [core_idx_w(NUM_CORES)-1:0]     tgt_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 fatal_o
);

    localparam int IW = core_idx_w(NUM_CORES);
    localparam logic [ADDR_WIDTH-1:0] SPC_LAST = ADDR_WIDTH'(NUM_SPC - 1);
    localparam logic [ADDR_WIDTH-1:0] GPR_LAST = '1;

    logic [STATE_W-1:0]    state;
    logic [NUM_CORES-1:0]  pend_q, halt_q, win, healthy, tgt_oh, src_oh;
    logic [IW-1:0]         tgt_q, src_q, rr_ptr, win_idx, heal_idx;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  win_vld, copying, src_fail, last, tmo;

    rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_arb (
        .pend  (pend_q),
        .ptr   (rr_ptr),
        .grant (win),
        .valid (win_vld)
    );

    assign healthy = ~pend_q & ~error_i;
    assign tgt_oh  = NUM_CORES'(1) << tgt_q;
    assign src_oh  = NUM_CORES'(1) << src_q;
    assign copying = state == ST_COPY_SPC || state == ST_COPY_GPR;
    assign last    = state == ST_COPY_SPC ? cnt == SPC_LAST : cnt == GPR_LAST;
    assign src_fail = (state == ST_HALT || copying) && error_i[src_q];

    always_comb begin
        win_idx  = '0;
        heal_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (win[i]) win_idx = IW'(i);
            if (healthy[i]) heal_idx = IW'(i);
        end
    end

`ifdef RECOVERY_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_q;
    assign tmo = copying && !rf_gnt_i && wait_q == WW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) wait_q <= '0;
        else wait_q <= (copying && !rf_gnt_i) ? wait_q + 1'b1 : '0;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES > 0;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            pend_q <= '0;
            halt_q <= '0;
            tgt_q  <= '0;
            src_q  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            // New errors are OR-ed in after the clear so a coincident set wins.
            pend_q <= (pend_q & ~(state == ST_RESUME ? tgt_oh : '0)) | error_i;
            case (state)
                ST_IDLE:
                    if (win_vld) begin
                        if (healthy == '0) begin
                            state  <= ST_FATAL;
                            halt_q <= '1;
                        end else begin
                            state  <= ST_HALT;
                            tgt_q  <= win_idx;
                            src_q  <= heal_idx;
                            halt_q <= halt_q | win | (NUM_CORES'(1) << heal_idx);
                        end
                    end
                ST_HALT: begin
                    cnt   <= '0;
                    state <= ST_COPY_SPC;
                end
                ST_COPY_SPC, ST_COPY_GPR:
                    if (rf_gnt_i) begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last && state == ST_COPY_SPC) state <= ST_COPY_GPR;
                        if (last && state == ST_COPY_GPR) begin
                            state  <= ST_RESUME;
                            halt_q <= halt_q & ~(tgt_oh | src_oh);
                        end
                    end
                ST_RESUME: begin
                    state  <= ST_IDLE;
                    rr_ptr <= tgt_q == IW'(NUM_CORES - 1) ? '0 : tgt_q + 1'b1;
                end
                ST_FATAL: halt_q <= '1;
                default: state <= ST_IDLE;
            endcase
            // The failed source releases its halt; the old target stays halted
            // until the arbiter picks it again.
            if (src_fail) begin
                state  <= ST_IDLE;
                halt_q <= halt_q & ~src_oh;
            end
            if (tmo) begin
                state  <= ST_FATAL;
                halt_q <= '1;
            end
        end
    end

    assign halt_o    = halt_q;
    assign resume_o  = state == ST_RESUME ? tgt_oh | src_oh : '0;
    assign rf_req_o  = copying;
    assign rf_spc_o  = state == ST_COPY_SPC;
    assign rf_addr_o = copying ? cnt : '0;
    assign src_o     = src_q;
    assign tgt_o     = tgt_q;
    assign busy_o    = state != ST_IDLE;
    assign done_o    = state == ST_RESUME;
    assign fatal_o   = state == ST_FATAL;

endmodule

// File: tb/tb_recovery_scheduler.sv
// tb_recovery_scheduler: scoreboard bench for recovery_scheduler with default parameters
module tb_recovery_scheduler;

    logic       clk, rst_ni, rf_gnt_i;
    logic [2:0] error_i, halt_o, resume_o;
    logic       rf_req_o, rf_spc_o, busy_o, done_o, fatal_o;
    logic [4:0] rf_addr_o;
    logic [1:0] src_o, tgt_o;

    int errors = 0;
    int checks = 0;

    logic [9:0] xq[$];
    logic [6:0] dq[$];

    recovery_scheduler dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .error_i   (error_i),
        .halt_o    (halt_o),
        .resume_o  (resume_o),
        .rf_req_o  (rf_req_o),
        .rf_gnt_i  (rf_gnt_i),
        .rf_spc_o  (rf_spc_o),
        .rf_addr_o (rf_addr_o),
        .src_o     (src_o),
        .tgt_o     (tgt_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .fatal_o   (fatal_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_xfer(input logic spc, input int addr, input logic [1:0] s, input logic [1:0] t);
        xq.push_back({spc, 5'(addr), s, t});
    endtask

    task automatic push_round(input logic [1:0] s, input logic [1:0] t);
        for (int i = 0; i < 4; i++) push_xfer(1'b1, i, s, t);
        for (int i = 0; i < 32; i++) push_xfer(1'b0, i, s, t);
        dq.push_back({(3'b001 << s) | (3'b001 << t), s, t});
    endtask

    task automatic wait_done(input int n, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            step();
            if (done_o) seen++;
        end
        chk("done_count", seen, n);
    endtask

    task automatic wait_gpr(input int addr, input int budget);
        logic hit = 0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (rf_req_o && !rf_spc_o && rf_addr_o == 5'(addr)) begin
                hit = 1;
                break;
            end
        end
        chk("reach_gpr_addr", hit, 1);
    endtask

    // Monitor: every accepted transfer and every completion is matched against the queues.
    always @(negedge clk) begin
        if (rf_req_o && rf_gnt_i) begin
            if (xq.size() == 0) chk("xfer_unexpected", {rf_spc_o, rf_addr_o, src_o, tgt_o}, 10'h3ff);
            else chk("xfer", {rf_spc_o, rf_addr_o, src_o, tgt_o}, xq.pop_front());
        end
        if (done_o) begin
            if (dq.size() == 0) chk("done_unexpected", {resume_o, src_o, tgt_o}, 7'h7f);
            else chk("resume", {resume_o, src_o, tgt_o}, dq.pop_front());
        end
    end

    initial begin
        int lat;
        rst_ni = 0;
        error_i = 0;
        rf_gnt_i = 0;
        repeat (3) step();
        chk("rst_halt", halt_o, 0);
        chk("rst_resume", resume_o, 0);
        chk("rst_req", rf_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fatal", fatal_o, 0);
        rst_ni = 1;
        rf_gnt_i = 1;
        repeat (2) step();

        // Single error on core 1, grant tied high
        push_round(2'd0, 2'd1);
        error_i = 3'b010;
        step();
        error_i = 0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 1) chk("halt_pair", halt_o, 3'b011);
            if (resume_o != 0) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, 38);
        chk("resume_mask", resume_o, 3'b011);
        chk("done_pulse", done_o, 1);
        step();
        chk("halt_released", halt_o, 0);
        chk("idle_after", busy_o, 0);
        chk("done_one_cycle", done_o, 0);

        // Backpressure at GPR 7 while recovering core 0 from core 1
        push_round(2'd1, 2'd0);
        error_i = 3'b001;
        step();
        error_i = 0;
        wait_gpr(7, 100);
        rf_gnt_i = 0;
        repeat (5) begin
            step();
            chk("bp_addr_hold", {rf_req_o, rf_spc_o, rf_addr_o}, {2'b10, 5'd7});
        end
        rf_gnt_i = 1;
        step();
        chk("bp_addr_next", rf_addr_o, 8);
        wait_done(1, 100);

        // Round-robin: cores 1 and 2 fail together
        push_round(2'd0, 2'd1);
        push_round(2'd0, 2'd2);
        error_i = 3'b110;
        step();
        error_i = 0;
        wait_done(2, 200);

        // Source core 0 fails while copying into core 2 at GPR 10
        for (int i = 0; i < 4; i++) push_xfer(1'b1, i, 2'd0, 2'd2);
        for (int i = 0; i < 10; i++) push_xfer(1'b0, i, 2'd0, 2'd2);
        push_round(2'd1, 2'd0);
        push_round(2'd0, 2'd2);
        error_i = 3'b100;
        step();
        error_i = 0;
        wait_gpr(10, 100);
        error_i = 3'b001;
        rf_gnt_i = 0;
        step();
        error_i = 0;
        rf_gnt_i = 1;
        chk("abort_idle", busy_o, 0);
        chk("abort_halt", halt_o, 3'b100);
        for (int c = 0; c < 20 && !rf_req_o; c++) step();
        chk("restart_first", {rf_spc_o, rf_addr_o, src_o, tgt_o}, {1'b1, 5'd0, 2'd1, 2'd0});
        chk("restart_halt", halt_o, 3'b111);
        wait_done(2, 300);
        chk("halt_clear_end", halt_o, 0);

        // No healthy core
        error_i = 3'b111;
        step();
        error_i = 0;
        repeat (3) step();
        chk("fatal_flag", fatal_o, 1);
        chk("fatal_halt", halt_o, 3'b111);
        chk("fatal_req", rf_req_o, 0);
        repeat (10) step();
        chk("fatal_sticky", {fatal_o, halt_o, busy_o}, {1'b1, 3'b111, 1'b1});
        rst_ni = 0;
        #1;
        chk("reset_clears_fatal", {fatal_o, halt_o, busy_o}, 0);

        chk("xfer_queue_empty", xq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
